id_ex_pipe_reg: RTL

ID/EX pipeline register. Captures the decode-stage control word from the control flush mux, plus register operands, immediate, PC+1 and register addresses, and presents them to the execute stage one cycle later. Supports a hold on stall, bubble insertion on flush, a valid bit, and a saturating bubble counter for performance debug.

---
 rtl/id_ex_pipe_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decode control, operands and register
// addresses for execute; supports stall hold, flush bubbles and a bubble counter.
module id_ex_pipe_reg #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  valid_id,
   input  logic [1:0]            regDst,
   input  logic                  gt_bra,
   input  logic                  le_bra,
   input  logic                  eq_bra,
   input  logic                  memRead,
   input  logic [1:0]            memToReg,
   input  logic [2:0]            aluOp,
   input  logic                  memWrite,
   input  logic                  regWrite,
   input  logic                  jump,
   input  logic                  seOp,
   input  logic [DATA_W-1:0]     pc_plus1_id,
   input  logic [DATA_W-1:0]     rd_data1_id,
   input  logic [DATA_W-1:0]     rd_data2_id,
   input  logic [DATA_W-1:0]     imm_id,
   input  logic [REG_ADDR_W-1:0] rs_id,
   input  logic [REG_ADDR_W-1:0] rt_id,
   input  logic [REG_ADDR_W-1:0] rd_id,
   output logic [1:0]            regDst_ex,
   output logic                  gt_bra_ex,
   output logic                  le_bra_ex,
   output logic                  eq_bra_ex,
   output logic                  memRead_ex,
   output logic [1:0]            memToReg_ex,
   output logic [2:0]            aluOp_ex,
   output logic                  memWrite_ex,
   output logic                  regWrite_ex,
   output logic                  jump_ex,
   output logic                  seOp_ex,
   output logic [DATA_W-1:0]     pc_plus1_ex,
   output logic [DATA_W-1:0]     rd_data1_ex,
   output logic [DATA_W-1:0]     rd_data2_ex,
   output logic [DATA_W-1:0]     imm_ex,
   output logic [REG_ADDR_W-1:0] rs_ex,
   output logic [REG_ADDR_W-1:0] rt_ex,
   output logic [REG_ADDR_W-1:0] rd_ex,
   output logic                  valid_ex,
   output logic [CNT_W-1:0]      bubble_count
);

   // Reset and flush both leave a fully zeroed stage, so they share one branch.
   logic clearStage;
   logic counterSat;

   assign clearStage = !rst_n || flush;
   assign counterSat = &bubble_count;

   always_ff @(posedge clk) begin
      if (clearStage) begin
         regDst_ex   <= '0;
         gt_bra_ex   <= 1'b0;
         le_bra_ex   <= 1'b0;
         eq_bra_ex   <= 1'b0;
         memRead_ex  <= 1'b0;
         memToReg_ex <= '0;
         aluOp_ex    <= '0;
         memWrite_ex <= 1'b0;
         regWrite_ex <= 1'b0;
         jump_ex     <= 1'b0;
         seOp_ex     <= 1'b0;
         pc_plus1_ex <= '0;
         rd_data1_ex <= '0;
         rd_data2_ex <= '0;
         imm_ex      <= '0;
         rs_ex       <= '0;
         rt_ex       <= '0;
         rd_ex       <= '0;
         valid_ex    <= 1'b0;
      end else if (!stall) begin
         regDst_ex   <= regDst;
         gt_bra_ex   <= gt_bra;
         le_bra_ex   <= le_bra;
         eq_bra_ex   <= eq_bra;
         memRead_ex  <= memRead;
         memToReg_ex <= memToReg;
         aluOp_ex    <= aluOp;
         memWrite_ex <= memWrite;
         regWrite_ex <= regWrite;
         jump_ex     <= jump;
         seOp_ex     <= seOp;
         pc_plus1_ex <= pc_plus1_id;
         rd_data1_ex <= rd_data1_id;
         rd_data2_ex <= rd_data2_id;
         imm_ex      <= imm_id;
         rs_ex       <= rs_id;
         rt_ex       <= rt_id;
         rd_ex       <= rd_id;
         valid_ex    <= valid_id;
      end
   end

   // Counts flush bubbles only; stalls and loads leave it alone, and it sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bubble_count <= '0;
      end else if (flush && !counterSat) begin
         bubble_count <= bubble_count + CNT_W'(1);
      end
   end

endmodule
